// File: rtl/signmag_serial_addsub_if.sv
// Operand/result bundle for the bit-serial sign-magnitude add/sub unit.
// master drives the operation request, slave is the arithmetic unit.
interface signmag_serial_addsub_if #(
    parameter int MAG_W = 7
);
    logic             start;
    logic             sub;
    logic             a_sign;
    logic [MAG_W-1:0] a_mag;
    logic             b_sign;
    logic [MAG_W-1:0] b_mag;
    logic             busy;
    logic             done;
    logic             res_sign;
    logic [MAG_W-1:0] res_mag;
    logic             overflow;

    modport master (
        output start, sub, a_sign, a_mag, b_sign, b_mag,
        input  busy, done, res_sign, res_mag, overflow
    );

    modport slave (
        input  start, sub, a_sign, a_mag, b_sign, b_mag,
        output busy, done, res_sign, res_mag, overflow
    );
endinterface

// File: rtl/signmag_serial_addsub.sv
// Bit-serial sign-magnitude A+B / A-B, one full-adder slice; SIGNMAG_SAT_EN saturates add overflow.
// Latency: done MAG_W edges after accept, 2*MAG_W when the result needs re-complementing.
// No backpressure: start is ignored while busy, there is no request queue.
module signmag_serial_addsub #(
    parameter int MAG_W = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    signmag_serial_addsub_if.slave  bus
);
    localparam int CW = $clog2(MAG_W) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [MAG_W-1:0] sa;
    logic [MAG_W-1:0] sb;
    logic [MAG_W-1:0] r;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             eff_sub;
    logic             a_sign_q;
    logic             sign_q;
    logic             seen;

    logic             bb;
    logic             s_bit;
    logic             c_next;
    logic             fix_bit;
    logic             last;
    logic             fin;
    logic             fin_ovf;
    logic             fin_sign_raw;
    logic             fin_sign;
    logic [MAG_W-1:0] r_next;
    logic [MAG_W-1:0] fin_mag;

    always_comb begin
        bb           = sb[0] ^ eff_sub;
        s_bit        = sa[0] ^ bb ^ carry;
        c_next       = (sa[0] & bb) | (sa[0] & carry) | (bb & carry);
        fix_bit      = seen ? ~r[0] : r[0];
        last         = (cnt == CW'(MAG_W - 1));
        r_next       = r;
        fin          = 1'b0;
        fin_ovf      = 1'b0;
        fin_sign_raw = a_sign_q;
        case (state)
            S_ADD: begin
                r_next  = {s_bit, r[MAG_W-1:1]};
                // a subtract without carry-out left R in two's complement: go fix it first
                fin     = last && (!eff_sub || c_next);
                fin_ovf = !eff_sub && c_next;
            end
            S_FIX: begin
                r_next       = {fix_bit, r[MAG_W-1:1]};
                fin          = last;
                fin_sign_raw = sign_q;
            end
            default: ;
        endcase
        // zero magnitude reports positive, unless it is the wrapped residue of an overflow
        fin_sign = fin_sign_raw & ((|r_next) | fin_ovf);
`ifdef SIGNMAG_SAT_EN
        fin_mag  = fin_ovf ? {MAG_W{1'b1}} : r_next;
`else
        fin_mag  = r_next;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            sa           <= '0;
            sb           <= '0;
            r            <= '0;
            cnt          <= '0;
            carry        <= 1'b0;
            eff_sub      <= 1'b0;
            a_sign_q     <= 1'b0;
            sign_q       <= 1'b0;
            seen         <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.res_sign <= 1'b0;
            bus.res_mag  <= '0;
            bus.overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        sa       <= bus.a_mag;
                        sb       <= bus.b_mag;
                        eff_sub  <= bus.a_sign ^ bus.b_sign ^ bus.sub;
                        carry    <= bus.a_sign ^ bus.b_sign ^ bus.sub;
                        a_sign_q <= bus.a_sign;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= S_ADD;
                    end
                end
                S_ADD: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    carry <= c_next;
                    r     <= r_next;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        if (fin) begin
                            state <= S_DONE;
                        end else begin
                            state  <= S_FIX;
                            sign_q <= ~a_sign_q;
                            cnt    <= '0;
                            seen   <= 1'b0;
                        end
                    end
                end
                S_FIX: begin
                    r    <= r_next;
                    seen <= seen | r[0];
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
            if (fin) begin
                bus.res_mag  <= fin_mag;
                bus.res_sign <= fin_sign;
                bus.overflow <= fin_ovf;
                bus.done     <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_signmag_serial_addsub.sv
// Scoreboard bench: an acceptor predicts each accepted op from signed integer arithmetic,
// a monitor checks every done pulse (value, timing, busy handshake) against that queue.
module tb_signmag_serial_addsub;
    localparam int W    = 7;
    localparam int MAXM = (1 << W) - 1;

    typedef struct {
        logic         sgn;
        logic [W-1:0] mag;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    signmag_serial_addsub_if #(.MAG_W(W)) bus ();
    signmag_serial_addsub #(.MAG_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   n_acc      = 0;
    logic prev_done  = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input bit s, input bit as, input int am,
                                   input bit bs, input int bm, input int now);
        exp_t e;
        int   va, vb, sum, mg;
        va    = as ? -am : am;
        vb    = (bs ^ s) ? -bm : bm;
        sum   = va + vb;
        mg    = (sum < 0) ? -sum : sum;
        e.ovf = (mg > MAXM);
        if (e.ovf) begin
`ifdef SIGNMAG_SAT_EN
            e.mag = W'(MAXM);
`else
            e.mag = W'(mg % (MAXM + 1));
`endif
            e.sgn = as;
        end else begin
            e.mag = W'(mg);
            e.sgn = (sum < 0);
        end
        e.cyc = now + 1 + (((as != (bs ^ s)) && (bm > am)) ? 2 * W : W);
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // acceptor: an IDLE unit with start asserted takes the op at the coming edge
    always @(negedge clk) begin
        if (!rst && !bus.busy && bus.start) begin
            q.push_back(model(bus.sub, bus.a_sign, int'(bus.a_mag),
                              bus.b_sign, int'(bus.b_mag), cyc));
            n_acc++;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (prev_done) begin
                chk("busy_after_done", int'(bus.busy), 0);
                chk("done_one_cycle", int'(bus.done), 0);
            end
            if (bus.done && !prev_done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("res_sign", int'(bus.res_sign), int'(e.sgn));
                    chk("res_mag", int'(bus.res_mag), int'(e.mag));
                    chk("overflow", int'(bus.overflow), int'(e.ovf));
                    chk("done_cycle", cyc, e.cyc);
                    chk("busy_at_done", int'(bus.busy), 1);
                end
            end
            prev_done = bus.done;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("idle_timeout", 1, 0);
    endtask

    task automatic drive(input bit s, input bit as, input int am, input bit bs, input int bm);
        bus.sub    = s;
        bus.a_sign = as;
        bus.a_mag  = W'(am);
        bus.b_sign = bs;
        bus.b_mag  = W'(bm);
    endtask

    task automatic scramble();
        drive(1'($urandom), 1'($urandom), int'($urandom_range(0, MAXM)),
              1'($urandom), int'($urandom_range(0, MAXM)));
    endtask

    task automatic issue(input bit s, input bit as, input int am, input bit bs, input int bm);
        wait_idle();
        drive(s, as, am, bs, bm);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        scramble();
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        chk("drain", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d ops pending", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        rst       = 1'b1;
        bus.start = 1'b0;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_res_sign", int'(bus.res_sign), 0);
        chk("rst_res_mag", int'(bus.res_mag), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // +5 + +3, with the busy window measured
        issue(0, 0, 5, 0, 3);
        n = 1;
        while (bus.busy && n < 50) begin
            @(posedge clk);
            #1;
            if (bus.busy) n++;
        end
        chk("busy_cycles", n, W + 1);

        issue(1, 0, 5, 0, 9);
        issue(0, 1, 20, 0, 20);
        issue(0, 0, 100, 0, 50);
        issue(1, 0, 33, 0, 33);
        issue(1, 1, 0, 1, 0);
        issue(0, 0, 64, 0, 64);
        wait_drain();

        // start held high: two back-to-back ops of -64 + -1
        wait_idle();
        drive(0, 1, 64, 1, 1);
        bus.start = 1'b1;
        base = n_acc;
        n = 0;
        while (n_acc < base + 2 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        bus.start = 1'b0;
        chk("held_start_accepts", n_acc - base, 2);
        wait_drain();

        // a start pulse during ADD must be ignored
        issue(1, 1, 30, 0, 12);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        drive(0, 0, 77, 0, 11);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_drain();

        // reset in the middle of ADD aborts without a done pulse
        issue(0, 1, 9, 1, 4);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_res_sign", int'(bus.res_sign), 0);
        chk("abort_res_mag", int'(bus.res_mag), 0);
        chk("abort_overflow", int'(bus.overflow), 0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(0, 0, 1, 0, 1);
        wait_drain();

        repeat (150) begin
            int am, bm;
            am = int'($urandom_range(0, MAXM));
            bm = ($urandom_range(0, 7) == 0) ? am : int'($urandom_range(0, MAXM));
            issue(1'($urandom), 1'($urandom), am, 1'($urandom), bm);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
